// File: rtl/nios2_control_button_irq_master_pkg.sv
// Shared definitions for the button PIO interrupt master.
// PIO register offsets, FSM state encoding and bus command helpers.
package nios2_control_button_irq_master_pkg;

    localparam logic [1:0] PIO_OFS_DATA = 2'd0;
    localparam logic [1:0] PIO_OFS_MASK = 2'd2;
    localparam logic [1:0] PIO_OFS_EDGE = 2'd3;

    // Any write to the edge-capture register clears every bit.
    localparam logic [31:0] PIO_CLR_ALL = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_WR_MASK   = 4'd0,
        ST_CLR0      = 4'd1,
        ST_IDLE      = 4'd2,
        ST_RD_CAP    = 4'd3,
        ST_CAP_WAIT  = 4'd4,
        ST_CLR_CAP   = 4'd5,
        ST_RD_DATA   = 4'd6,
        ST_DATA_WAIT = 4'd7,
        ST_REPORT    = 4'd8,
        ST_HOLD      = 4'd9
    } state_e;

    // One registered Avalon-MM command.
    typedef struct packed {
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
    } bus_cmd_t;

    localparam bus_cmd_t BUS_RESET = '{
        addr:  2'd0,
        cs:    1'b0,
        wr_n:  1'b1,
        wdata: 32'd0
    };

    function automatic bus_cmd_t bus_write(
        input logic [1:0]  a,
        input logic [31:0] d
    );
        return '{addr: a, cs: 1'b1, wr_n: 1'b0, wdata: d};
    endfunction

    // Reads keep the previous write data on the bus.
    function automatic bus_cmd_t bus_read(
        input logic [1:0] a,
        input bus_cmd_t   cur
    );
        return '{addr: a, cs: 1'b1, wr_n: 1'b1, wdata: cur.wdata};
    endfunction

    // Idle bus: strobes off, address and data hold.
    function automatic bus_cmd_t bus_idle(input bus_cmd_t cur);
        return '{addr: cur.addr, cs: 1'b0, wr_n: 1'b1, wdata: cur.wdata};
    endfunction

endpackage

// File: rtl/nios2_control_button_irq_master_if.sv
// Avalon-MM link between the irq master and the button PIO s1 port.
// master: drives address/chipselect/write_n/writedata, samples readdata.
interface nios2_control_button_irq_master_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/nios2_control_button_irq_master_holdoff_timer.sv
// Debounce hold-off down-counter.
// load_i: restart at CYCLES; done_o: high in the last counted cycle.
module nios2_control_holdoff_timer #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    output logic done_o
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Values CYCLES..1 each occupy one cycle, so the
    // caller leaves after exactly CYCLES cycles.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/nios2_control_button_irq_master.sv
// Hardware master servicing the button PIO without the CPU.
// Ports: clk, reset_n, enable, mask_cfg, irq, avm (bus master),
// evt_valid/evt_edges/evt_level/evt_count (event report), busy.
module nios2_control_button_irq_master
    import nios2_control_button_irq_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int HOLDOFF_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] mask_cfg,
    input  logic                  irq,
    nios2_control_button_irq_master_if.master avm,
    output logic                  evt_valid,
    output logic [DATA_WIDTH-1:0] evt_edges,
    output logic [DATA_WIDTH-1:0] evt_level,
    output logic [CNT_W-1:0]      evt_count,
    output logic                  busy
);

    state_e                state_q, state_d;
    bus_cmd_t              cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] level_q, level_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] edges_q, edges_d;
    logic [DATA_WIDTH-1:0] elevel_q, elevel_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  busy_q, busy_d;

    logic                  hold_load;
    logic                  hold_done;
    logic [31:0]           mask_wdata;
    logic [DATA_WIDTH-1:0] rd_bits;
    logic                  unused_rdata;

    assign mask_wdata   = 32'(mask_cfg);
    assign rd_bits      = avm.avm_readdata[DATA_WIDTH-1:0];
    assign unused_rdata = ^avm.avm_readdata;

    nios2_control_holdoff_timer #(
        .CYCLES (HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (hold_load),
        .done_o  (hold_done)
    );

    // Bus commands are registered together with the state
    // they belong to, so each state's bus cycle is on the
    // wires while the FSM sits in that state.
    always_comb begin
        state_d   = state_q;
        cmd_d     = bus_idle(cmd_q);
        shadow_d  = shadow_q;
        cap_d     = cap_q;
        level_d   = level_q;
        valid_d   = 1'b0;
        edges_d   = edges_q;
        elevel_d  = elevel_q;
        count_d   = count_q;
        hold_load = 1'b0;

        unique case (state_q)
            ST_WR_MASK: begin
                // Out of reset nothing has been issued yet,
                // so spend one cycle driving the mask write.
                if (!cmd_q.cs) begin
                    cmd_d    = bus_write(PIO_OFS_MASK, mask_wdata);
                    shadow_d = mask_cfg;
                end else begin
                    state_d = ST_CLR0;
                    cmd_d   = bus_write(PIO_OFS_EDGE, PIO_CLR_ALL);
                end
            end
            ST_CLR0: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (mask_cfg != shadow_q) begin
                    state_d  = ST_WR_MASK;
                    cmd_d    = bus_write(PIO_OFS_MASK, mask_wdata);
                    shadow_d = mask_cfg;
                end else if (enable && irq) begin
                    state_d = ST_RD_CAP;
                    cmd_d   = bus_read(PIO_OFS_EDGE, cmd_q);
                end
            end
            ST_RD_CAP: begin
                state_d = ST_CAP_WAIT;
            end
            ST_CAP_WAIT: begin
                state_d = ST_CLR_CAP;
                cap_d   = rd_bits & shadow_q;
                cmd_d   = bus_write(PIO_OFS_EDGE, PIO_CLR_ALL);
            end
            ST_CLR_CAP: begin
                state_d = ST_RD_DATA;
                cmd_d   = bus_read(PIO_OFS_DATA, cmd_q);
            end
            ST_RD_DATA: begin
                state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                state_d = ST_REPORT;
                level_d = rd_bits;
            end
            ST_REPORT: begin
                state_d   = ST_HOLD;
                hold_load = 1'b1;
                // An irq whose capture is fully masked is
                // spurious and leaves the report untouched.
                if (cap_q != '0) begin
                    valid_d  = 1'b1;
                    edges_d  = cap_q;
                    elevel_d = level_q;
                    count_d  = count_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // Bounce edges pile up in the PIO here and
                // are flushed by the CLR0 write.
                if (hold_done) begin
                    state_d = ST_CLR0;
                    cmd_d   = bus_write(PIO_OFS_EDGE, PIO_CLR_ALL);
                end
            end
            default: begin
                state_d = ST_WR_MASK;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WR_MASK;
            cmd_q    <= BUS_RESET;
            shadow_q <= '0;
            cap_q    <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            edges_q  <= '0;
            elevel_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            shadow_q <= shadow_d;
            cap_q    <= cap_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            edges_q  <= edges_d;
            elevel_q <= elevel_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign avm.avm_address    = cmd_q.addr;
    assign avm.avm_chipselect = cmd_q.cs;
    assign avm.avm_write_n    = cmd_q.wr_n;
    assign avm.avm_writedata  = cmd_q.wdata;

    assign evt_valid = valid_q;
    assign evt_edges = edges_q;
    assign evt_level = elevel_q;
    assign evt_count = count_q;
    assign busy      = busy_q;

endmodule
